// File: rtl/conv_accum.sv
// Window accumulator: sums NTAPS products, scales and saturates the sum, and hands the pixel out on valid/ready.
// Optional per-window bias input is enabled by defining CONV_ACCUM_BIAS_EN.
module conv_accum #(
   parameter int NTAPS = 9,
   parameter int ACC_W = 12,
   parameter int OUT_W = 8,
   parameter int SHIFT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             prod_valid,
   input  logic [7:0]       product,
`ifdef CONV_ACCUM_BIAS_EN
   input  logic [7:0]       bias,
`endif
   input  logic             out_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic             out_sat,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

   localparam int SW = ACC_W + 1;
   localparam int CW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
   localparam logic [7:0]       LAST_CNT    = 8'(NTAPS - 1);
   localparam logic [ACC_W-1:0] ACC_MAX     = {ACC_W{1'b1}};
   localparam logic [OUT_W-1:0] OUT_MAX     = {OUT_W{1'b1}};
   localparam logic [CW-1:0]    OUT_MAX_EXT = CW'(OUT_MAX);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               sat_q, sat_d;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic               out_sat_q, out_sat_d;

   logic [SW-1:0]      sum;
   logic [ACC_W-1:0]   acc_add;
   logic               sat_add;
   logic [ACC_W-1:0]   shifted;
   logic [CW-1:0]      shifted_ext;
   logic               clamp;
   logic [ACC_W-1:0]   acc_init;

`ifdef CONV_ACCUM_BIAS_EN
   assign acc_init = ACC_W'(bias);
`else
   assign acc_init = '0;
`endif

   // One extra bit catches the carry out so the accumulator can stick at full scale.
   assign sum         = {1'b0, acc_q} + SW'(product);
   assign acc_add     = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
   assign sat_add     = sat_q | sum[ACC_W];
   assign shifted     = acc_add >> SHIFT;
   assign shifted_ext = CW'(shifted);
   assign clamp       = (shifted_ext > OUT_MAX_EXT);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = acc_init;
               cnt_d   = '0;
               sat_d   = 1'b0;
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            // A restart wins over a product presented in the same cycle.
            if (start) begin
               acc_d = acc_init;
               cnt_d = '0;
               sat_d = 1'b0;
            end else if (prod_valid) begin
               acc_d = acc_add;
               sat_d = sat_add;
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == LAST_CNT) begin
                  state_d     = S_HOLD;
                  out_valid_d = 1'b1;
                  out_data_d  = clamp ? OUT_MAX : shifted_ext[OUT_W-1:0];
                  out_sat_d   = sat_add | clamp;
               end
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (start) begin
                  acc_d   = acc_init;
                  cnt_d   = '0;
                  sat_d   = 1'b0;
                  state_d = S_ACCUM;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_accum.sv
// Scoreboard bench for conv_accum: a default instance plus a SHIFT=4 instance driven by the same stimulus.
module tb_conv_accum;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       prod_valid = 1'b0;
   logic [7:0] product = 8'd0;
   logic [7:0] bias = 8'd0;
   logic       out_ready = 1'b1;
   logic       out_valid, out_sat, busy;
   logic [7:0] out_data;
   logic       out_valid4, out_sat4, busy4;
   logic [7:0] out_data4;

   conv_accum #(.NTAPS(9), .ACC_W(12), .OUT_W(8), .SHIFT(0)) dut (
      .clk(clk), .rst(rst), .start(start), .prod_valid(prod_valid), .product(product),
`ifdef CONV_ACCUM_BIAS_EN
      .bias(bias),
`endif
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_sat(out_sat), .busy(busy));

   conv_accum #(.NTAPS(9), .ACC_W(12), .OUT_W(8), .SHIFT(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .prod_valid(prod_valid), .product(product),
`ifdef CONV_ACCUM_BIAS_EN
      .bias(bias),
`endif
      .out_ready(out_ready), .out_valid(out_valid4), .out_data(out_data4),
      .out_sat(out_sat4), .busy(busy4));

   always #5 clk = ~clk;

   typedef struct {
      int         rise;
      logic [7:0] d;
      logic       s;
      logic [7:0] d4;
      logic       s4;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_t = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   // Monitor: latency on the rising edge of out_valid, data held every valid cycle, pop on handshake.
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got out_data %0d at cycle %0d, expected no output", out_data, cyc);
         end else begin
            if (!prev_valid) begin
               chk({exp_q[0].name, "_latency"}, cyc, exp_q[0].rise);
               $display("pixel %s: out_data=%0d out_sat=%0d shift4=%0d/%0d cycle=%0d",
                        exp_q[0].name, out_data, out_sat, out_data4, out_sat4, cyc);
            end
            chk({exp_q[0].name, "_data"}, out_data, exp_q[0].d);
            chk({exp_q[0].name, "_sat"}, out_sat, exp_q[0].s);
            chk({exp_q[0].name, "_valid4"}, out_valid4, 1);
            chk({exp_q[0].name, "_data4"}, out_data4, exp_q[0].d4);
            chk({exp_q[0].name, "_sat4"}, out_sat4, exp_q[0].s4);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
      prev_valid <= out_valid;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [7:0] b);
      start = 1'b1;
      bias  = b;
      step();
      start = 1'b0;
   endtask

   task automatic prod(input logic [7:0] p);
      prod_valid = 1'b1;
      product    = p;
      last_t     = cyc;
      step();
      prod_valid = 1'b0;
   endtask

   task automatic push(input string name, input logic [7:0] d, input logic s,
                       input logic [7:0] d4, input logic s4);
      exp_t e;
      e.rise = last_t + 1;
      e.d = d; e.s = s; e.d4 = d4; e.s4 = s4; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic run_window(input string name, input logic [7:0] p, input bit gap,
                             input logic [7:0] b, input logic [7:0] d, input logic s,
                             input logic [7:0] d4, input logic s4);
      pulse_start(b);
      for (int i = 0; i < 9; i++) begin
         prod(p);
         if (gap && i < 8) step();
      end
      push(name, d, s, d4, s4);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         step();
         n++;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
      step();
   endtask

   initial begin
      step();
      #2 rst = 1'b1;
      step();
      chk("reset_valid", out_valid, 0);
      chk("reset_data", out_data, 0);
      chk("reset_sat", out_sat, 0);
      chk("reset_busy", busy, 0);

      run_window("basic", 8'd10, 1'b0, 8'd0, 8'd90, 1'b0, 8'd5, 1'b0);
      drain("basic");
      chk("basic_idle_busy", busy, 0);

      run_window("bubble", 8'd20, 1'b1, 8'd0, 8'd180, 1'b0, 8'd11, 1'b0);
      drain("bubble");

      run_window("clamp", 8'd255, 1'b0, 8'd0, 8'd255, 1'b1, 8'd143, 1'b0);
      drain("clamp");

      // Backpressure with products arriving while the pixel is held, then restart on the handshake.
      out_ready = 1'b0;
      run_window("hold", 8'd25, 1'b0, 8'd0, 8'd225, 1'b0, 8'd14, 1'b0);
      for (int i = 0; i < 3; i++) prod(8'd99);
      chk("hold_busy", busy, 1);
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      start     = 1'b0;
      chk("restart_busy", busy, 1);
      for (int i = 0; i < 9; i++) prod(8'd3);
      push("after_hold", 8'd27, 1'b0, 8'd1, 1'b0);
      drain("after_hold");

      // Abort: restart mid-window with a product in the same cycle that must be dropped.
      pulse_start(8'd0);
      for (int i = 0; i < 4; i++) prod(8'd50);
      start      = 1'b1;
      prod_valid = 1'b1;
      product    = 8'd50;
      step();
      start      = 1'b0;
      prod_valid = 1'b0;
      for (int i = 0; i < 9; i++) prod(8'd1);
      push("abort", 8'd9, 1'b0, 8'd0, 1'b0);
      drain("abort");

      // Asynchronous reset mid-window clears outputs without a clock edge.
      pulse_start(8'd0);
      for (int i = 0; i < 5; i++) prod(8'd40);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_data", out_data, 0);
      chk("async_rst_sat", out_sat, 0);
      #3 rst = 1'b1;
      step();
      run_window("post_reset", 8'd12, 1'b0, 8'd0, 8'd108, 1'b0, 8'd6, 1'b0);
      drain("post_reset");

`ifdef CONV_ACCUM_BIAS_EN
      run_window("bias", 8'd10, 1'b0, 8'd7, 8'd97, 1'b0, 8'd6, 1'b0);
      drain("bias");
`endif

      repeat (3) step();
      chk("end_queue_empty", exp_q.size(), 0);
      chk("end_busy", busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_accum.md
Name: conv_accum

Overview:
- Downstream consumer of the registered 8-bit product stream from the conv-layer multiplier mux.
- Sums NTAPS products belonging to one kernel window (3x3 = 9 taps by default).
- Scales the sum and saturates it to an OUT_W output pixel.
- Presents the pixel on a valid/ready output handshake to the next stage (pooling/activation).

Parameters:
- NTAPS, 9, products accumulated per output pixel (legal 1..255).
- ACC_W, 12, accumulator width in bits (must hold NTAPS*255 without overflow at default).
- OUT_W, 8, output pixel width.
- SHIFT, 0, right shift applied to the final sum before saturation (0..ACC_W-1).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; opens a new window.
- prod_valid  input  1  product is valid this cycle.
- product  input  8  unsigned product from the multiplier stage.
- out_ready  input  1  downstream accepts out_data.
- out_valid  output  1  out_data holds a finished pixel.
- out_data  output  OUT_W  saturated, scaled window sum.
- out_sat  output  1  out_data was clamped (sum>>SHIFT exceeded 2^OUT_W-1, or accumulator saturated).
- busy  output  1  high in ACCUM and HOLD.

Behaviour:
- Reset (rst low, asynchronous) takes effect immediately, including mid-window: state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0, busy=0. The in-progress window is discarded.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - prod_valid is ignored.
  - On start: acc<=0 (or bias, see optional feature), cnt<=0, go to ACCUM.
- ACCUM:
  - Each cycle with prod_valid=1: acc<=acc+product, cnt<=cnt+1.
  - Cycles with prod_valid=0 are bubbles: no change, no timeout.
  - When the product accepted has cnt==NTAPS-1, the next state is HOLD.
  - On the HOLD entry edge: out_data = min((acc_final>>SHIFT), 2^OUT_W-1), out_sat set accordingly, out_valid<=1.
  - Latency: out_valid rises exactly 1 cycle after the last product is accepted.
  - start during ACCUM aborts the current window. acc and cnt are reinitialised, the state stays ACCUM, and any prod_valid in that same cycle is dropped.
- Accumulator arithmetic:
  - Unsigned, ACC_W bits.
  - If acc+product exceeds 2^ACC_W-1, acc holds at 2^ACC_W-1 and the internal sticky sat flag is set for this window.
  - out_sat = sticky sat OR output clamp.
- HOLD:
  - out_valid=1; out_data and out_sat are held stable until the handshake completes.
  - prod_valid is ignored; products arriving here are dropped.
  - On out_valid&&out_ready: out_valid<=0. Next state is ACCUM (reinitialised) if start is high in the same cycle, otherwise IDLE.
  - start without out_ready in HOLD is ignored.
- busy is a combinational decode of state != IDLE.
- NTAPS=1: out_valid follows one cycle after the single accepted product.

Optional Feature:
- Macro: CONV_ACCUM_BIAS_EN.
- Defined:
  - Adds input port bias [7:0], an unsigned per-window bias.
  - bias is sampled on the start cycle and loaded as the initial acc value instead of 0.
  - This applies to both IDLE start and start-during-ACCUM/HOLD-restart.
  - Saturation rules are unchanged.
- Undefined:
  - No bias port; acc always initialises to 0.

Test Plan:
- Basic window: start, then 9 consecutive products of 10 with out_ready=1 -> out_valid 1 cycle after the 9th, out_data=90, out_sat=0; returns to IDLE, busy=0.
- Bubbles: 9 products of 20 with prod_valid low every other cycle -> out_data=180, out_valid 1 cycle after the 9th accepted product, no early assertion.
- Clamp: 9 products of 255 -> acc=2295, out_data=255, out_sat=1; with SHIFT=4 -> out_data=143, out_sat=0.
- Backpressure: out_ready held low 3 cycles after out_valid, with extra prod_valid pulses during HOLD -> out_data stable, products dropped; on ready, start in the same cycle -> directly ACCUM and the next window sums correctly.
- Abort and reset: start, 4 products of 50, start again, 9 products of 1 -> out_data=9. Separately, rst low after 5 products -> all outputs 0 immediately, and the following window is unaffected.
- Bias (CONV_ACCUM_BIAS_EN): bias=7, 9 products of 10 -> out_data=97.
